// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: sequencer state
// encoding and default geometry.
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    DUMP  = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_seq.sv
// Sequencer for regfile_param: CLEAR/IDLE/DUMP FSM sharing one index counter.
// Emits the clear write strobe and the next-cycle dump load/index.
module regfile_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dumpReq,
  output logic              busy,
  output logic              clearWe,
  output logic [ADDR_W-1:0] clearAddr,
  output logic              dumpLoad,
  output logic [ADDR_W-1:0] dumpIdx
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  state_t           state, nextState;
  logic [IDX_W-1:0] idx, nextIdx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      state <= nextState;
      idx   <= nextIdx;
    end
  end

  always_comb begin
    nextState = state;
    nextIdx   = idx;
    busy      = 1'b0;
    clearWe   = 1'b0;
    case (state)
      CLEAR: begin
        busy    = 1'b1;
        clearWe = 1'b1;
        if (idx == LAST_IDX) begin
          nextState = IDLE;
          nextIdx   = '0;
        end else begin
          nextIdx = idx + IDX_W'(1);
        end
      end
      IDLE: begin
        if (dumpReq) begin
          nextState = DUMP;
          nextIdx   = '0;
        end
      end
      DUMP: begin
        // Requests arriving mid-scan are ignored; the scan always runs to the end.
        if (idx == LAST_IDX) begin
          nextState = IDLE;
          nextIdx   = '0;
        end else begin
          nextIdx = idx + IDX_W'(1);
        end
      end
      default: begin
        nextState = CLEAR;
        nextIdx   = '0;
      end
    endcase
  end

  assign clearAddr = idx[ADDR_W-1:0];

  // The dump output registers load from the upcoming index so the first beat
  // is visible the cycle right after the request is sampled.
  assign dumpLoad = !reset && (nextState == DUMP);
  assign dumpIdx  = nextIdx[ADDR_W-1:0];

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one write port,
// post-reset hardware clear and sequential dump channel.
// Optional same-cycle write-to-read forwarding under REGFILE_WRITE_BYPASS_EN.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rw_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_en,
  input  logic              dump_req,
  output logic [DATA_W-1:0] rs,
  output logic [DATA_W-1:0] rt,
  output logic              busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data
);

  localparam int NREGS  = 2 ** ADDR_W;
  localparam bit ZeroEn = (ZERO_REG != 0);

  logic [NREGS-1:0][DATA_W-1:0] mem;

  logic              clearWe;
  logic [ADDR_W-1:0] clearAddr;
  logic              dumpLoad;
  logic [ADDR_W-1:0] dumpIdx;
  logic              wrOk;

  regfile_seq #(.ADDR_W(ADDR_W)) uSeq (
    .clk       (clk),
    .reset     (reset),
    .dumpReq   (dump_req),
    .busy      (busy),
    .clearWe   (clearWe),
    .clearAddr (clearAddr),
    .dumpLoad  (dumpLoad),
    .dumpIdx   (dumpIdx)
  );

  assign wrOk = w_en && !busy && !(ZeroEn && (rw_addr == '0));

  // Storage is only ever zeroed by the clear sweep, never by reset directly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clearWe)
        mem[clearAddr] <= '0;
      else if (wrOk)
        mem[rw_addr] <= w_data;
    end
  end

  // Sampling mem at the same edge as a write yields the pre-write value.
  always_ff @(posedge clk) begin
    if (reset) begin
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      dump_valid <= dumpLoad;
      dump_addr  <= dumpLoad ? dumpIdx : '0;
      dump_data  <= dumpLoad ? mem[dumpIdx] : '0;
    end
  end

  always_comb begin
    rs = mem[rs_addr];
    rt = mem[rt_addr];
    if (ZeroEn && (rs_addr == '0)) rs = '0;
    if (ZeroEn && (rt_addr == '0)) rt = '0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wrOk && (rw_addr == rs_addr)) rs = w_data;
    if (wrOk && (rw_addr == rt_addr)) rt = w_data;
`endif
    if (busy) begin
      rs = '0;
      rt = '0;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: vector table, randomized traffic
// against an array model, and hand-written clear/dump/reset sequences.
module tb_regfile_param;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  rs_addr, rt_addr, rw_addr;
  logic [15:0] w_data;
  logic        w_en, dump_req;
  logic [15:0] rs, rt;
  logic        busy, dump_valid;
  logic [3:0]  dump_addr;
  logic [15:0] dump_data;

  int checks = 0;
  int errors = 0;
  logic [15:0] model [16];

  regfile_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rw_addr(rw_addr), .w_data(w_data), .w_en(w_en), .dump_req(dump_req),
    .rs(rs), .rt(rt), .busy(busy), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_data(dump_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wEn;
    logic [3:0]  rwA;
    logic [15:0] wData;
    logic [3:0]  rsA, rtA;
    logic [15:0] expRs, expRt, expRsB, expRtB;
  } vec_t;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] expRead(input logic [3:0] a, input logic we,
                                          input logic [3:0] wa, input logic [15:0] wd);
    if (a == 4'd0) return 16'h0;
    if (BYP && we && wa == a) return wd;
    return model[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs through the clear sweep, hammering writes/dump requests that must be dropped.
  task automatic countBusy();
    int n = 0;
    while (busy === 1'b1 && n < 64) begin
      rs_addr  = 4'($urandom_range(0, 15));
      rt_addr  = 4'($urandom_range(0, 15));
      w_en     = 1'b1;
      rw_addr  = 4'd5;
      w_data   = 16'h1234;
      dump_req = n[0];
      #1;
      chk("clear_rs", rs, 16'h0);
      chk("clear_rt", rt, 16'h0);
      n++;
      tick();
    end
    w_en = 1'b0;
    dump_req = 1'b0;
    chk("busy_cycles", 16'(n), 16'd16);
    chk("dv_after_clear", {15'h0, dump_valid}, 16'h0);
    for (int i = 0; i < 16; i++) model[i] = 16'h0;
  endtask

  task automatic doDump(input int wrBeat, input int rstBeat, input int reReqBeat);
    logic [15:0] snap [16];
    for (int i = 0; i < 16; i++) snap[i] = model[i];
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("dump_valid", {15'h0, dump_valid}, 16'h1);
      chk("dump_addr", {12'h0, dump_addr}, 16'(k));
      chk("dump_data", dump_data, snap[k]);
      if (k == rstBeat) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_dump_valid", {15'h0, dump_valid}, 16'h0);
        chk("rst_busy", {15'h0, busy}, 16'h1);
        countBusy();
        return;
      end
      if (k == wrBeat) begin
        w_en = 1'b1;
        rw_addr = 4'(k);
        w_data = 16'hAAAA;
        model[k] = 16'hAAAA;
      end
      dump_req = (k == reReqBeat);
      tick();
      w_en = 1'b0;
      dump_req = 1'b0;
    end
    chk("dump_end_valid", {15'h0, dump_valid}, 16'h0);
  endtask

  initial begin
    vec_t vecs [8];
    vecs[0] = '{1'b1, 4'd0,  16'h0001, 4'd0,  4'd3,  16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 4'd3,  16'hBEEF, 4'd0,  4'd3,  16'h0000, 16'h0000, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b0, 4'd3,  16'h0000, 4'd0,  4'd3,  16'h0000, 16'hBEEF, 16'h0000, 16'hBEEF};
    vecs[3] = '{1'b1, 4'd15, 16'h5A5A, 4'd15, 4'd15, 16'h0000, 16'h0000, 16'h5A5A, 16'h5A5A};
    vecs[4] = '{1'b1, 4'd0,  16'hFFFF, 4'd0,  4'd15, 16'h0000, 16'h5A5A, 16'h0000, 16'h5A5A};
    vecs[5] = '{1'b0, 4'd15, 16'h1111, 4'd15, 4'd3,  16'h5A5A, 16'hBEEF, 16'h5A5A, 16'hBEEF};
    vecs[6] = '{1'b1, 4'd3,  16'h0042, 4'd3,  4'd0,  16'hBEEF, 16'h0000, 16'h0042, 16'h0000};
    vecs[7] = '{1'b0, 4'd3,  16'h0000, 4'd3,  4'd5,  16'h0042, 16'h0000, 16'h0042, 16'h0000};

    reset = 1'b1; w_en = 1'b0; dump_req = 1'b0;
    rs_addr = '0; rt_addr = '0; rw_addr = '0; w_data = '0;
    tick();
    chk("rst_busy", {15'h0, busy}, 16'h1);
    chk("rst_dump_valid", {15'h0, dump_valid}, 16'h0);
    chk("rst_dump_addr", {12'h0, dump_addr}, 16'h0);
    chk("rst_dump_data", dump_data, 16'h0);
    tick();
    reset = 1'b0;
    countBusy();

    for (int a = 0; a < 16; a++) begin
      rs_addr = 4'(a);
      rt_addr = 4'(15 - a);
      #1;
      chk("post_clear_rs", rs, 16'h0);
      chk("post_clear_rt", rt, 16'h0);
    end

    for (int v = 0; v < 8; v++) begin
      w_en = vecs[v].wEn; rw_addr = vecs[v].rwA; w_data = vecs[v].wData;
      rs_addr = vecs[v].rsA; rt_addr = vecs[v].rtA;
      #1;
      chk($sformatf("vec%0d_rs", v), rs, BYP ? vecs[v].expRsB : vecs[v].expRs);
      chk($sformatf("vec%0d_rt", v), rt, BYP ? vecs[v].expRtB : vecs[v].expRt);
      tick();
      if (vecs[v].wEn && vecs[v].rwA != 4'd0) model[vecs[v].rwA] = vecs[v].wData;
    end
    w_en = 1'b0;

    for (int c = 0; c < 300; c++) begin
      w_en    = 1'($urandom_range(0, 1));
      rw_addr = 4'($urandom_range(0, 15));
      w_data  = 16'($urandom);
      rs_addr = ($urandom_range(0, 3) == 0) ? rw_addr : 4'($urandom_range(0, 15));
      rt_addr = 4'($urandom_range(0, 15));
      #1;
      chk("rand_rs", rs, expRead(rs_addr, w_en, rw_addr, w_data));
      chk("rand_rt", rt, expRead(rt_addr, w_en, rw_addr, w_data));
      tick();
      if (w_en && rw_addr != 4'd0) model[rw_addr] = w_data;
    end
    w_en = 1'b0;
    chk("rand_no_dump", {15'h0, dump_valid}, 16'h0);

    for (int i = 1; i < 16; i++) begin
      w_en = 1'b1; rw_addr = 4'(i); w_data = 16'(i * 16'h0101);
      tick();
      model[i] = 16'(i * 16'h0101);
    end
    w_en = 1'b0;

    doDump(-1, -1, 3);
    doDump(7, -1, -1);
    chk("model_r7", model[7], 16'hAAAA);
    doDump(-1, -1, -1);
    doDump(-1, 4, -1);

    for (int a = 0; a < 16; a++) begin
      rs_addr = 4'(a);
      #1;
      chk("post_reset_clear", rs, 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
